regfile_wb_sched: RTL and testbench

Writeback scheduler and busy scoreboard for the 8-entry, 16-bit, 2-write-port register file. It accepts writeback requests from up to NREQ execution units over valid/ready, grants at most two per cycle with round-robin fairness, and drives the register file's two write ports from a registered stage. It also tracks which registers have an issued-but-not-yet-written producer, so issue logic can stall on read-after-write hazards.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/rr_pick2.sv | 47 ++++
 rtl/regfile_wb_sched.sv | 87 ++++++++
 tb/tb_regfile_wb_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file geometry and register-number/data types
package regfile_pkg;
  localparam int NREGS = 8;
  localparam int AW = 3;
  localparam int DW = 16;
  typedef logic [AW-1:0] reg_num_t;
  typedef logic [DW-1:0] reg_data_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-grant round-robin picker with destination-conflict exclusion
//   valid_i   requester valid vector
//   num_i     destination register per requester, requester i at [i*AW +: AW]
//   ptr_i     round-robin start index
//   grant_o   one-hot-or-two grant vector
//   a_idx_o/b_idx_o, a_found_o/b_found_o  port-0 / port-1 winners
module rr_pick2 #(
  parameter int NREQ = 4,
  parameter int AW = 3,
  parameter int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]    valid_i,
  input  logic [NREQ*AW-1:0] num_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NREQ-1:0]    grant_o,
  output logic [PW-1:0]      a_idx_o,
  output logic [PW-1:0]      b_idx_o,
  output logic               a_found_o,
  output logic               b_found_o
);
  logic [AW-1:0] a_num;
  int idx;
  always_comb begin
    grant_o = '0;
    a_idx_o = '0;
    b_idx_o = '0;
    a_found_o = 1'b0;
    b_found_o = 1'b0;
    a_num = '0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (valid_i[idx] && !a_found_o) begin
        a_found_o = 1'b1;
        a_idx_o = PW'(idx);
        a_num = num_i[idx*AW +: AW];
        grant_o[idx] = 1'b1;
      end else if (valid_i[idx] && !b_found_o && num_i[idx*AW +: AW] != a_num) begin
        // same-destination losers are skipped, not blocking later requesters
        b_found_o = 1'b1;
        b_idx_o = PW'(idx);
        grant_o[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: two-port writeback scheduler and busy scoreboard for the register file
//   req_valid_in/req_ready_out  per-requester handshake (ready is combinational)
//   req_num_in/req_data_in      per-requester destination and data
//   issue_in/issue_num_in       marks a register as awaiting writeback
//   busy_out                    registers with an outstanding producer
//   write*_out/num_write*_out/data_write*_out  registered register-file write ports
module regfile_wb_sched #(
  parameter int NREQ = 4,
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int AW = regfile_pkg::AW,
  parameter int DW = regfile_pkg::DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid_in,
  output logic [NREQ-1:0]    req_ready_out,
  input  logic [NREQ*AW-1:0] req_num_in,
  input  logic [NREQ*DW-1:0] req_data_in,
  input  logic               issue_in,
  input  logic [AW-1:0]      issue_num_in,
  output logic [NREGS-1:0]   busy_out,
  output logic               write0_out,
  output logic               write1_out,
  output logic [AW-1:0]      num_write0_out,
  output logic [AW-1:0]      num_write1_out,
  output logic [DW-1:0]      data_write0_out,
  output logic [DW-1:0]      data_write1_out
);
  localparam int PW = $clog2(NREQ);
  logic [NREQ-1:0] grant;
  logic [PW-1:0] a_idx, b_idx, last, rr_q, rr_d;
  logic a_found, b_found;
  logic w0_q, w1_q;
  logic [AW-1:0] n0_q, n0_d, n1_q, n1_d;
  logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [NREGS-1:0] busy_q, busy_d;
  rr_pick2 #(.NREQ(NREQ), .AW(AW), .PW(PW)) u_pick (
    .valid_i(req_valid_in),
    .num_i(req_num_in),
    .ptr_i(rr_q),
    .grant_o(grant),
    .a_idx_o(a_idx),
    .b_idx_o(b_idx),
    .a_found_o(a_found),
    .b_found_o(b_found)
  );
  // no transfer can complete while reset is held
  assign req_ready_out = rst_n ? grant : '0;
  always_comb begin
    last = b_found ? b_idx : a_idx;
    rr_d = a_found ? ((last == PW'(NREQ - 1)) ? '0 : last + 1'b1) : rr_q;
    n0_d = a_found ? req_num_in[a_idx*AW +: AW] : n0_q;
    d0_d = a_found ? req_data_in[a_idx*DW +: DW] : d0_q;
    n1_d = b_found ? req_num_in[b_idx*AW +: AW] : n1_q;
    d1_d = b_found ? req_data_in[b_idx*DW +: DW] : d1_q;
    // set is applied after the clears so a fresh producer wins
    busy_d = (busy_q & ~(NREGS'(w0_q) << n0_q) & ~(NREGS'(w1_q) << n1_q)) | (NREGS'(issue_in) << issue_num_in);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
      w0_q <= 1'b0;
      w1_q <= 1'b0;
      n0_q <= '0;
      n1_q <= '0;
      d0_q <= '0;
      d1_q <= '0;
      busy_q <= '0;
    end else begin
      rr_q <= rr_d;
      w0_q <= a_found;
      w1_q <= b_found;
      n0_q <= n0_d;
      n1_q <= n1_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
      busy_q <= busy_d;
    end
  end
  assign busy_out = busy_q;
  assign write0_out = w0_q;
  assign write1_out = w1_q;
  assign num_write0_out = n0_q;
  assign num_write1_out = n1_q;
  assign data_write0_out = d0_q;
  assign data_write1_out = d1_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: table-driven, directed and randomized checks against a behavioural model
module tb_regfile_wb_sched;
  localparam int NREQ = 4, NREGS = 8, AW = 3, DW = 16;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [NREQ-1:0] req_valid_in, req_ready_out;
  logic [NREQ*AW-1:0] req_num_in;
  logic [NREQ*DW-1:0] req_data_in;
  logic issue_in = 1'b0;
  logic [AW-1:0] issue_num_in = '0;
  logic [NREGS-1:0] busy_out;
  logic write0_out, write1_out;
  logic [AW-1:0] num_write0_out, num_write1_out;
  logic [DW-1:0] data_write0_out, data_write1_out;
  logic pv[NREQ];
  logic [AW-1:0] pn[NREQ];
  logic [DW-1:0] pd[NREQ];
  int errors = 0, checks = 0;
  int m_ptr;
  logic [NREGS-1:0] m_busy;
  logic m_w0, m_w1;
  logic [AW-1:0] m_n0, m_n1;
  logic [DW-1:0] m_d0, m_d1;
  logic [NREQ-1:0] last_ready;
  typedef struct {
    bit rst;
    logic [NREQ-1:0] v;
    logic [NREQ*AW-1:0] n;
    logic [NREQ-1:0] ready;
  } vec_t;
  vec_t tbl[6];
  regfile_wb_sched #(.NREQ(NREQ), .NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_num_in(req_num_in), .req_data_in(req_data_in),
    .issue_in(issue_in), .issue_num_in(issue_num_in),
    .busy_out(busy_out),
    .write0_out(write0_out), .write1_out(write1_out),
    .num_write0_out(num_write0_out), .num_write1_out(num_write1_out),
    .data_write0_out(data_write0_out), .data_write1_out(data_write1_out)
  );
  always #5 clk = ~clk;
  always_comb begin
    req_valid_in = '0;
    req_num_in = '0;
    req_data_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid_in[i] = pv[i];
      req_num_in[i*AW +: AW] = pn[i];
      req_data_in[i*DW +: DW] = pd[i];
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // visit requesters in rotated order starting at ptr; first pending wins port 0,
  // next pending with a different destination wins port 1
  function automatic void pick(input int ptr, output logic [NREQ-1:0] g, output int a, output int b);
    int ord[$];
    g = '0;
    a = -1;
    b = -1;
    for (int k = 0; k < NREQ; k++) ord.push_back((ptr + k) % NREQ);
    foreach (ord[j]) begin
      int i;
      i = ord[j];
      if (pv[i]) begin
        if (a < 0) begin
          a = i;
          g[i] = 1'b1;
        end else if (b < 0 && pn[i] != pn[a]) begin
          b = i;
          g[i] = 1'b1;
        end
      end
    end
  endfunction
  task automatic m_reset();
    m_ptr = 0;
    m_busy = '0;
    m_w0 = 1'b0;
    m_w1 = 1'b0;
    m_n0 = '0;
    m_n1 = '0;
    m_d0 = '0;
    m_d1 = '0;
  endtask
  task automatic step();
    logic [NREQ-1:0] g;
    logic [NREGS-1:0] nb;
    int a, b;
    @(negedge clk);
    pick(m_ptr, g, a, b);
    last_ready = req_ready_out;
    chk("ready", req_ready_out, g);
    chk("write0", write0_out, m_w0);
    chk("write1", write1_out, m_w1);
    chk("num0", num_write0_out, m_n0);
    chk("num1", num_write1_out, m_n1);
    chk("data0", data_write0_out, m_d0);
    chk("data1", data_write1_out, m_d1);
    chk("busy", busy_out, m_busy);
    chk("distinct", write0_out && write1_out && num_write0_out == num_write1_out, 0);
    nb = m_busy;
    if (m_w0) nb[m_n0] = 1'b0;
    if (m_w1) nb[m_n1] = 1'b0;
    if (issue_in) nb[issue_num_in] = 1'b1;
    m_busy = nb;
    m_w0 = a >= 0;
    m_w1 = b >= 0;
    if (a >= 0) begin
      m_n0 = pn[a];
      m_d0 = pd[a];
      m_ptr = ((b >= 0 ? b : a) + 1) % NREQ;
    end
    if (b >= 0) begin
      m_n1 = pn[b];
      m_d1 = pd[b];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (g[i]) pv[i] = 1'b0;
  endtask
  // asserts reset between clock edges and checks the outputs fall without a clock
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_ready", req_ready_out, 0);
    chk("rst_write0", write0_out, 0);
    chk("rst_write1", write1_out, 0);
    chk("rst_num0", num_write0_out, 0);
    chk("rst_data0", data_write0_out, 0);
    chk("rst_data1", data_write1_out, 0);
    chk("rst_busy", busy_out, 0);
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    issue_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pv[i] = 1'b1;
      pn[i] = AW'(i + 1);
      pd[i] = 16'hF0F0;
    end
    m_reset();
    #1;
    do_reset();
    step();
    chk("idle_write0", write0_out, 0);
    step();
    chk("idle_write1", write1_out, 0);
    pv[0] = 1'b1; pn[0] = 3'd2; pd[0] = 16'hAAAA;
    pv[1] = 1'b1; pn[1] = 3'd5; pd[1] = 16'h5555;
    step();
    chk("dist_ready", last_ready, 4'b0011);
    chk("dist_w0", {write0_out, num_write0_out, data_write0_out}, {1'b1, 3'd2, 16'hAAAA});
    chk("dist_w1", {write1_out, num_write1_out, data_write1_out}, {1'b1, 3'd5, 16'h5555});
    step();
    tbl[0] = '{1'b1, 4'b1111, {3'd6, 3'd3, 3'd3, 3'd3}, 4'b1001};
    tbl[1] = '{1'b0, 4'b0110, {3'd6, 3'd3, 3'd3, 3'd3}, 4'b0010};
    tbl[2] = '{1'b0, 4'b0100, {3'd6, 3'd3, 3'd3, 3'd3}, 4'b0100};
    tbl[3] = '{1'b1, 4'b1111, {3'd7, 3'd6, 3'd5, 3'd4}, 4'b0011};
    tbl[4] = '{1'b0, 4'b1111, {3'd7, 3'd6, 3'd5, 3'd4}, 4'b1100};
    tbl[5] = '{1'b0, 4'b1111, {3'd7, 3'd6, 3'd5, 3'd4}, 4'b0011};
    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      for (int i = 0; i < NREQ; i++) begin
        pv[i] = tbl[k].v[i];
        pn[i] = tbl[k].n[i*AW +: AW];
        pd[i] = {4'(i), 4'(pn[i]), 8'hA5};
      end
      step();
      chk("tbl_ready", last_ready, tbl[k].ready);
    end
    step();
    do_reset();
    issue_in = 1'b1; issue_num_in = 3'd4;
    step();
    issue_in = 1'b0;
    chk("sb_set", busy_out[4], 1);
    step();
    step();
    pv[0] = 1'b1; pn[0] = 3'd4; pd[0] = 16'h1234;
    step();
    chk("sb_wr", {write0_out, busy_out[4]}, 2'b11);
    step();
    chk("sb_clr", busy_out[4], 0);
    issue_in = 1'b1;
    step();
    issue_in = 1'b0;
    pv[0] = 1'b1; pd[0] = 16'h4321;
    step();
    issue_in = 1'b1;
    step();
    issue_in = 1'b0;
    chk("sb_set_wins", busy_out[4], 1);
    step();
    chk("sb_hold", busy_out[4], 1);
    pv[0] = 1'b1; pn[0] = 3'd1; pd[0] = 16'hBEEF;
    issue_in = 1'b1; issue_num_in = 3'd1;
    step();
    issue_in = 1'b0;
    chk("mid_w0", write0_out, 1);
    do_reset();
    pv[0] = 1'b1; pn[0] = 3'd2; pd[0] = 16'h1111;
    pv[3] = 1'b1; pn[3] = 3'd5; pd[3] = 16'h3333;
    step();
    chk("ptr_restart", {num_write0_out, data_write0_out}, {3'd2, 16'h1111});
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i] = 1'b1;
          pn[i] = AW'($urandom_range(0, c < 200 ? 7 : 1));
          pd[i] = DW'($urandom);
        end
      issue_in = 1'($urandom_range(0, 1));
      issue_num_in = AW'($urandom_range(0, 7));
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
